ex_md_unit: RTL

Multi-cycle RV32M execute unit that sits beside the single-cycle execute stage. It is parametrised in datapath width and multiplier throughput. It accepts one multiply/divide/remainder operation at a time and holds the pipeline via `busy_o`. It returns the result with its destination register address as a one-cycle write-back pulse, on the same `ex_w_reg_*` path the execute stage already drives.

---
 rtl/ex_md_unit.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/ex_md_unit.sv
// ex_md_unit: multi-cycle RV32M multiply/divide/remainder unit.
// Holds the pipeline through busy_o and returns the result as a one-cycle
// write-back pulse on the ex_w_reg_* path.
// Optional feature macro: EX_MD_EARLY_OUT_EN (divide-by-zero and signed
// overflow skip CALC and finish two cycles after accept).
`timescale 1ns/1ps
module ex_md_unit #(
  parameter int unsigned XLEN               = 32,
  parameter int unsigned MUL_BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] src1_i,
  input  logic [XLEN-1:0] src2_i,
  input  logic [4:0]      w_reg_addr_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            ex_w_reg_enable_o,
  output logic [4:0]      w_reg_addr_o,
  output logic [XLEN-1:0] ex_w_reg_data_o
);

  localparam int unsigned M          = MUL_BITS_PER_CYCLE;
  localparam int unsigned CW         = $clog2(XLEN + 1);
  localparam logic [CW-1:0] K_MUL_LAST = CW'(XLEN / M - 1);
  localparam logic [CW-1:0] K_DIV_LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] SMIN     = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIXUP, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [4:0]        rd_q, rd_d;
  logic [XLEN-1:0]   opa_q, opa_d;   // multiplicand / divisor magnitude
  logic [XLEN-1:0]   opb_q, opb_d;   // multiplier / dividend magnitude (shifted)
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              sa_q, sa_d, sb_q, sb_d;
  logic              dz_q, dz_d, ovf_q, ovf_d;
  logic              busy_q, busy_d, wen_q, wen_d;
  logic [4:0]        waddr_q, waddr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;

  logic              sgn1, sgn2, neg1, neg2, div_zero, div_ovf;
  logic [XLEN-1:0]   mag1, mag2;
  logic [XLEN+M-1:0] mul_pp, mul_sum;
  logic [2*XLEN-1:0] mul_next, div_next, prod_f;
  logic [XLEN:0]     div_r, div_diff;
  logic              div_qbit;
  logic [XLEN-1:0]   quot_f, rem_f, result;

  // Operand decode at accept: signedness, magnitudes, special divide cases
  always_comb begin
    sgn1     = op_i[2] ? ~op_i[0] : (op_i[1] ^ op_i[0]);
    sgn2     = op_i[2] ? ~op_i[0] : (op_i[1:0] == 2'b01);
    neg1     = sgn1 & src1_i[XLEN-1];
    neg2     = sgn2 & src2_i[XLEN-1];
    mag1     = neg1 ? -src1_i : src1_i;
    mag2     = neg2 ? -src2_i : src2_i;
    div_zero = op_i[2] & (src2_i == '0);
    div_ovf  = op_i[2] & ~op_i[0] & (src1_i == SMIN) & (&src2_i);
  end

  // Iteration datapath: shift-add multiply step and restoring divide step
  always_comb begin
    // Partial product enters at the top of the accumulator, then everything
    // shifts right by M; after XLEN/M steps the full product sits in acc.
    mul_pp   = {{M{1'b0}}, opa_q} * {{XLEN{1'b0}}, opb_q[M-1:0]};
    mul_sum  = {{M{1'b0}}, acc_q[2*XLEN-1:XLEN]} + mul_pp;
    mul_next = {mul_sum, acc_q[XLEN-1:M]};
    // acc high half is the partial remainder, low half collects quotient bits.
    div_r    = {acc_q[2*XLEN-1:XLEN], opb_q[XLEN-1]};
    div_diff = div_r - {1'b0, opa_q};
    div_qbit = ~div_diff[XLEN];
    div_next = {(div_qbit ? div_diff[XLEN-1:0] : div_r[XLEN-1:0]),
                acc_q[XLEN-2:0], div_qbit};
  end

  // Sign fixup and special-case results
  always_comb begin
    prod_f = (sa_q ^ sb_q) ? -acc_q : acc_q;
    quot_f = (sa_q ^ sb_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_f  = sa_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    if (ovf_q) begin
      quot_f = SMIN;
      rem_f  = '0;
    end
    if (dz_q) begin
      quot_f = '1;
`ifdef EX_MD_EARLY_OUT_EN
      // CALC was skipped, so the dividend magnitude is still unshifted.
      rem_f  = sa_q ? -opb_q : opb_q;
`endif
    end
    if (!op_q[2]) begin
      result = (op_q[1:0] == 2'b00) ? prod_f[XLEN-1:0] : prod_f[2*XLEN-1:XLEN];
    end else begin
      result = op_q[1] ? rem_f : quot_f;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rd_d    = rd_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i && !flush_i) begin
          state_d = S_CALC;
          op_d    = op_i;
          rd_d    = w_reg_addr_i;
          opa_d   = op_i[2] ? mag2 : mag1;
          opb_d   = op_i[2] ? mag1 : mag2;
          sa_d    = neg1;
          sb_d    = neg2;
          dz_d    = div_zero;
          ovf_d   = div_ovf;
          acc_d   = '0;
          cnt_d   = '0;
`ifdef EX_MD_EARLY_OUT_EN
          if (div_zero || div_ovf) state_d = S_FIXUP;
`endif
        end
      end
      S_CALC: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else begin
          acc_d = op_q[2] ? div_next : mul_next;
          opb_d = op_q[2] ? (opb_q << 1) : (opb_q >> M);
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == (op_q[2] ? K_DIV_LAST : K_MUL_LAST)) state_d = S_FIXUP;
        end
      end
      S_FIXUP: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
          waddr_d = rd_q;
          wdata_d = result;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    wen_d  = (state_d == S_DONE);
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      rd_q    <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign busy_o            = busy_q;
  assign ex_w_reg_enable_o = wen_q;
  assign w_reg_addr_o      = waddr_q;
  assign ex_w_reg_data_o   = wdata_q;

endmodule
